// File: rtl/door_cmd_arbiter_if.sv
// Request/sensor inputs and key/grant outputs between the door command arbiter and its environment.
// Latency: none (wires only).
// Backpressure: none; requests are level-held by the requesters, and busy shows when they are ignored.
// Signals: wall_*/rem_* requests, auto_en, obstruct, sense_* door sensors -> arbiter;
//          key_up/key_down pulses, grant source code, busy <- arbiter.
interface door_cmd_arbiter_if;
    logic       wall_up;
    logic       wall_down;
    logic       rem_up;
    logic       rem_down;
    logic       auto_en;
    logic       obstruct;
    logic       sense_up;
    logic       sense_down;
    logic       key_up;
    logic       key_down;
    logic [2:0] grant;
    logic       busy;

    // Requester / door side
    modport master (
        output wall_up, wall_down, rem_up, rem_down, auto_en, obstruct, sense_up, sense_down,
        input  key_up, key_down, grant, busy
    );

    // Arbiter side
    modport slave (
        input  wall_up, wall_down, rem_up, rem_down, auto_en, obstruct, sense_up, sense_down,
        output key_up, key_down, grant, busy
    );
endinterface

// File: rtl/door_cmd_arbiter.sv
// Arbitrates wall/remote/auto-close/obstruction commands into fixed-length key pulses with a lockout.
// Latency: a request served in IDLE at edge N drives its key from cycle N+1; all outputs are registered.
// Backpressure: busy is high in DRIVE and LOCKOUT; requests other than obstruction are dropped there.
// Ports: clk2m, rst_n (sync, active-low), bus (slave side of door_cmd_arbiter_if).
module door_cmd_arbiter #(
    parameter int PULSE_LEN      = 4,
    parameter int LOCKOUT_CYC    = 2000,
    parameter int AUTO_CLOSE_CYC = 120000000,
    parameter int CNT_W          = 27
) (
    input  logic                clk2m,
    input  logic                rst_n,
    door_cmd_arbiter_if.slave   bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRIVE   = 2'd1;
    localparam logic [1:0] ST_LOCKOUT = 2'd2;

    localparam logic [2:0] G_NONE = 3'b000;
    localparam logic [2:0] G_WALL = 3'b001;
    localparam logic [2:0] G_REM  = 3'b010;
    localparam logic [2:0] G_AUTO = 3'b011;
    localparam logic [2:0] G_OBS  = 3'b100;

    localparam logic [3:0]       PULSE_LAST = 4'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_CYC - 1);
    localparam logic [CNT_W-1:0] AC_LAST    = CNT_W'(AUTO_CLOSE_CYC - 1);
    localparam logic [CNT_W-1:0] AC_PRE     = CNT_W'(AUTO_CLOSE_CYC - 2);

    logic [1:0]       r_state;
    logic [3:0]       r_pulse_cnt;
    logic [CNT_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0] r_ac_cnt;
    logic             r_ac_pend;
    logic             r_key_up;
    logic             r_key_down;
    logic [2:0]       r_grant;
    logic             r_busy;

    logic       w_obs_vld;
    logic       w_wall_vld;
    logic       w_rem_vld;
    logic       w_auto_vld;
    logic       w_sel_vld;
    logic       w_sel_up;
    logic [2:0] w_sel_grant;
    logic       w_preempt;
    logic       w_ac_cond;
    logic       w_ac_run;

    // A source asserting up is treated as an up request even if down is also held;
    // if that up is dropped by sense_up the source is simply skipped.
    assign w_obs_vld  = bus.obstruct && !bus.sense_up && !bus.sense_down;
    assign w_wall_vld = bus.wall_up ? !bus.sense_up
                                    : (bus.wall_down && !bus.sense_down && !bus.obstruct);
    assign w_rem_vld  = bus.rem_up  ? !bus.sense_up
                                    : (bus.rem_down && !bus.sense_down && !bus.obstruct);
    assign w_auto_vld = r_ac_pend && !bus.obstruct && !bus.sense_down;

    always_comb begin
        w_sel_vld   = 1'b0;
        w_sel_up    = 1'b0;
        w_sel_grant = G_NONE;
        if (w_obs_vld) begin
            w_sel_vld   = 1'b1;
            w_sel_up    = 1'b1;
            w_sel_grant = G_OBS;
        end else if (w_wall_vld) begin
            w_sel_vld   = 1'b1;
            w_sel_up    = bus.wall_up;
            w_sel_grant = G_WALL;
        end else if (w_rem_vld) begin
            w_sel_vld   = 1'b1;
            w_sel_up    = bus.rem_up;
            w_sel_grant = G_REM;
        end else if (w_auto_vld) begin
            w_sel_vld   = 1'b1;
            w_sel_up    = 1'b0;
            w_sel_grant = G_AUTO;
        end
    end

    // Obstruction cuts a closing pulse or the lockout short; an opening pulse runs on.
    assign w_preempt = bus.obstruct &&
                       (((r_state == ST_DRIVE) && r_key_down) || (r_state == ST_LOCKOUT));

    // The pending flag follows only the door/enable/obstruct condition, while the
    // counter additionally restarts whenever the arbiter leaves IDLE.
    assign w_ac_cond = bus.sense_up && bus.auto_en && !bus.obstruct;
    assign w_ac_run  = w_ac_cond && (r_state == ST_IDLE);

    always_ff @(posedge clk2m) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pulse_cnt <= '0;
            r_lock_cnt  <= '0;
            r_ac_cnt    <= '0;
            r_ac_pend   <= 1'b0;
            r_key_up    <= 1'b0;
            r_key_down  <= 1'b0;
            r_grant     <= G_NONE;
            r_busy      <= 1'b0;
        end else begin
            if (!w_ac_run) begin
                r_ac_cnt <= '0;
            end else if (r_ac_cnt != AC_LAST) begin
                r_ac_cnt <= r_ac_cnt + 1'b1;
            end
            // Flag rises on the same edge the count lands on its terminal value.
            if (!w_ac_cond) begin
                r_ac_pend <= 1'b0;
            end else if (w_ac_run && (r_ac_cnt == AC_PRE)) begin
                r_ac_pend <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_sel_vld) begin
                        r_state     <= ST_DRIVE;
                        r_key_up    <= w_sel_up;
                        r_key_down  <= !w_sel_up;
                        r_grant     <= w_sel_grant;
                        r_busy      <= 1'b1;
                        r_pulse_cnt <= '0;
                        if (w_sel_grant == G_AUTO) begin
                            r_ac_pend <= 1'b0;
                        end
                    end
                end
                ST_DRIVE, ST_LOCKOUT: begin
                    if (w_preempt) begin
                        r_state     <= ST_DRIVE;
                        r_key_up    <= 1'b1;
                        r_key_down  <= 1'b0;
                        r_grant     <= G_OBS;
                        r_busy      <= 1'b1;
                        r_pulse_cnt <= '0;
                    end else if (r_state == ST_DRIVE) begin
                        if (r_pulse_cnt == PULSE_LAST) begin
                            r_state    <= ST_LOCKOUT;
                            r_key_up   <= 1'b0;
                            r_key_down <= 1'b0;
                            r_grant    <= G_NONE;
                            r_lock_cnt <= '0;
                        end else begin
                            r_pulse_cnt <= r_pulse_cnt + 4'd1;
                        end
                    end else begin
                        if (r_lock_cnt == LOCK_LAST) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_key_up   <= 1'b0;
                    r_key_down <= 1'b0;
                    r_grant    <= G_NONE;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.key_up   = r_key_up;
    assign bus.key_down = r_key_down;
    assign bus.grant    = r_grant;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_door_cmd_arbiter.sv
// Self-checking bench for door_cmd_arbiter: expected key pulses are queued as stimulus is
// applied and matched against pulses observed on the outputs, plus direct timing/state checks.
// Uses AUTO_CLOSE_CYC=100 so the auto-close path fits in a short run.
module tb_door_cmd_arbiter;

    logic clk2m = 1'b0;
    logic rst_n;

    always #5 clk2m = ~clk2m;

    door_cmd_arbiter_if dif();

    door_cmd_arbiter #(
        .PULSE_LEN      (4),
        .LOCKOUT_CYC    (2000),
        .AUTO_CLOSE_CYC (100),
        .CNT_W          (27)
    ) dut (
        .clk2m (clk2m),
        .rst_n (rst_n),
        .bus   (dif)
    );

    // One expected pulse: {key_up, key_down, grant} and its length in cycles.
    typedef struct packed {
        logic [4:0]  sig;
        logic [31:0] len;
    } pulse_t;

    pulse_t exp_q[$];
    int     n_vec = 0;
    int     n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_pulse(input logic up, input logic [2:0] g, input int len);
        pulse_t p;
        p.sig = {up, !up, g};
        p.len = len;
        exp_q.push_back(p);
    endtask

    task automatic end_pulse(input logic [4:0] sig, input int len);
        pulse_t p;
        if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {27'd0, sig}, 32'd0);
        end else begin
            p = exp_q.pop_front();
            chk("pulse_sig", {27'd0, sig}, {27'd0, p.sig});
            chk("pulse_len", len, p.len);
        end
    endtask

    // Pulse monitor: a pulse is a run of cycles with a constant nonzero key signature.
    logic [4:0] mon_prev = 5'd0;
    int         mon_len  = 0;
    always @(negedge clk2m) begin
        logic [4:0] cur;
        cur = {dif.key_up, dif.key_down, dif.grant};
        if (cur !== mon_prev) begin
            if (mon_prev[4:3] != 2'b00) end_pulse(mon_prev, mon_len);
            mon_len = 1;
        end else begin
            mon_len++;
        end
        mon_prev = cur;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk2m);
        #1;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (dif.busy && cyc < 5000) begin
            tick(1);
            cyc++;
        end
        chk("idle_reached", {31'd0, dif.busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        rst_n          = 1'b0;
        dif.wall_up    = 1'b0;
        dif.wall_down  = 1'b0;
        dif.rem_up     = 1'b0;
        dif.rem_down   = 1'b0;
        dif.auto_en    = 1'b0;
        dif.obstruct   = 1'b0;
        dif.sense_up   = 1'b0;
        dif.sense_down = 1'b0;

        // 1. Reset holds everything low even with a request present.
        dif.wall_up = 1'b1;
        tick(3);
        chk("rst_key_up",   {31'd0, dif.key_up},   32'd0);
        chk("rst_key_down", {31'd0, dif.key_down}, 32'd0);
        chk("rst_grant",    {29'd0, dif.grant},    32'd0);
        chk("rst_busy",     {31'd0, dif.busy},     32'd0);
        rst_n = 1'b1;
        push_pulse(1'b1, 3'b001, 4);
        tick(1);
        chk("rel_key_up", {31'd0, dif.key_up}, 32'd1);
        dif.wall_up = 1'b0;
        tick(3);
        chk("pulse_last_cycle", {31'd0, dif.key_up}, 32'd1);
        tick(1);
        chk("pulse_end_key", {31'd0, dif.key_up}, 32'd0);
        chk("lockout_busy",  {31'd0, dif.busy},   32'd1);
        wait_idle(c);
        chk("lockout_len", c, 2000);

        // 2. Wall beats remote; remote held through lockout is served after busy falls.
        dif.wall_down = 1'b1;
        dif.rem_up    = 1'b1;
        push_pulse(1'b0, 3'b001, 4);
        push_pulse(1'b1, 3'b010, 4);
        tick(1);
        chk("arb_key_down", {31'd0, dif.key_down}, 32'd1);
        chk("arb_grant",    {29'd0, dif.grant},    32'd1);
        dif.wall_down = 1'b0;
        wait_idle(c);
        chk("rem_held_off", {31'd0, dif.key_up}, 32'd0);
        tick(1);
        chk("rem_served", {31'd0, dif.key_up}, 32'd1);
        chk("rem_grant",  {29'd0, dif.grant},  32'd2);
        dif.rem_up = 1'b0;
        wait_idle(c);

        // 3a. Up and down together: up wins.
        dif.wall_up   = 1'b1;
        dif.wall_down = 1'b1;
        push_pulse(1'b1, 3'b001, 4);
        tick(1);
        chk("both_key_up",   {31'd0, dif.key_up},   32'd1);
        chk("both_key_down", {31'd0, dif.key_down}, 32'd0);
        dif.wall_up   = 1'b0;
        dif.wall_down = 1'b0;
        wait_idle(c);

        // 3b. Down request on a closed door is dropped.
        dif.sense_down = 1'b1;
        dif.rem_down   = 1'b1;
        tick(5);
        chk("closed_drop_busy", {31'd0, dif.busy}, 32'd0);
        dif.rem_down   = 1'b0;
        dif.sense_down = 1'b0;

        // 4a. Obstruction on the second cycle of a closing pulse reverses it.
        dif.wall_down = 1'b1;
        push_pulse(1'b0, 3'b001, 2);
        push_pulse(1'b1, 3'b100, 4);
        tick(1);
        dif.wall_down = 1'b0;
        tick(1);
        dif.obstruct = 1'b1;
        dif.rem_down = 1'b1;
        tick(1);
        chk("preempt_key_up",   {31'd0, dif.key_up},   32'd1);
        chk("preempt_key_down", {31'd0, dif.key_down}, 32'd0);
        chk("preempt_grant",    {29'd0, dif.grant},    32'd4);
        tick(1);
        dif.obstruct = 1'b0;
        dif.rem_down = 1'b0;
        wait_idle(c);

        // 4b. Door open and obstructed: no obstruction pulse, remote down suppressed.
        dif.sense_up = 1'b1;
        dif.obstruct = 1'b1;
        dif.rem_down = 1'b1;
        tick(5);
        chk("obs_down_supp", {31'd0, dif.busy}, 32'd0);
        dif.rem_down = 1'b0;
        dif.obstruct = 1'b0;

        // 5. Auto-close: disabled gives nothing; an obstruction blip restarts the count.
        tick(150);
        chk("ac_disabled", {31'd0, dif.busy}, 32'd0);
        dif.auto_en = 1'b1;
        tick(50);
        dif.obstruct = 1'b1;
        tick(1);
        dif.obstruct = 1'b0;
        push_pulse(1'b0, 3'b011, 4);
        c = 0;
        while (!dif.key_down && c < 300) begin
            tick(1);
            c++;
        end
        chk("ac_delay", c, 100);
        chk("ac_grant", {29'd0, dif.grant}, 32'd3);
        dif.sense_up = 1'b0;
        dif.auto_en  = 1'b0;
        wait_idle(c);

        // 6. Reset in lockout with a held request, then immediate service after release.
        dif.wall_up = 1'b1;
        push_pulse(1'b1, 3'b001, 4);
        tick(1);
        tick(14);
        chk("pre_rst_busy", {31'd0, dif.busy}, 32'd1);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_busy",  {31'd0, dif.busy},   32'd0);
        chk("mid_rst_key",   {30'd0, dif.key_up, dif.key_down}, 32'd0);
        chk("mid_rst_grant", {29'd0, dif.grant},  32'd0);
        rst_n = 1'b1;
        push_pulse(1'b1, 3'b001, 4);
        tick(1);
        chk("post_rst_key_up", {31'd0, dif.key_up}, 32'd1);
        chk("post_rst_grant",  {29'd0, dif.grant},  32'd1);
        dif.wall_up = 1'b0;
        wait_idle(c);
        tick(2);

        chk("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/door_cmd_arbiter.md
Name: door_cmd_arbiter

Overview:
- Command scheduler in front of the garage door state machine.
- Arbitrates door commands from three requesters: wall panel, radio remote, and an internal auto-close timer.
- Issues fixed-length key_up/key_down pulses to the door FSM and enforces a lockout between commands.
- Forces re-open on obstruction, with obstruction taking priority over every requester.

Parameters:
- PULSE_LEN, 4: number of cycles key_up/key_down are held per command (1..15).
- LOCKOUT_CYC, 2000: idle cycles after a pulse before the next command is accepted (1 ms at 2 MHz).
- AUTO_CLOSE_CYC, 120000000: cycles the door must stay open and idle before auto-close fires (60 s at 2 MHz).
- CNT_W, 27: width of the lockout and auto-close counters; must hold AUTO_CLOSE_CYC-1 and LOCKOUT_CYC-1.

Ports:
- clk2m, input, 1: system clock, 2 MHz.
- rst_n, input, 1: synchronous active-low reset.
- wall_up, input, 1: wall panel up request (level).
- wall_down, input, 1: wall panel down request (level).
- rem_up, input, 1: remote up request (level).
- rem_down, input, 1: remote down request (level).
- auto_en, input, 1: enables the auto-close timer.
- obstruct, input, 1: light barrier blocked.
- sense_up, input, 1: door fully open.
- sense_down, input, 1: door fully closed.
- key_up, output, 1: up command to the door FSM.
- key_down, output, 1: down command to the door FSM.
- grant, output, 3: source being served: 000 none, 001 wall, 010 remote, 011 auto-close, 100 obstruction.
- busy, output, 1: high in DRIVE and LOCKOUT.

Behaviour:
Reset and clocking
- Single clock clk2m; reset is synchronous and active-low (rst_n).
- rst_n=0 at a clk2m edge sets, regardless of state: state IDLE, key_up=0, key_down=0, grant=000, busy=0, all counters 0, auto-close pending flag cleared.
- Reset mid-pulse truncates the pulse at that edge.
- All outputs are registered.

State machine
- States: IDLE, DRIVE, LOCKOUT.
- IDLE: evaluate requests every cycle. If a request is served at edge N, from cycle N+1:
  - state=DRIVE, exactly one of key_up/key_down = 1, grant = source code, busy=1, pulse counter = 0.
- DRIVE: hold the key for PULSE_LEN cycles, then key_up=key_down=0, grant=000, state=LOCKOUT, lockout counter = 0.
- LOCKOUT: busy=1; all requests except obstruction are ignored (not queued). After LOCKOUT_CYC cycles, go to IDLE with busy=0.

Priority (highest first), evaluated in IDLE
1. obstruct=1 and sense_up=0 and sense_down=0 → up, grant 100.
2. Wall panel.
3. Remote.
4. Auto-close pending → down, grant 011.

Request rules within a source
- up and down both asserted: up wins (safety).
- Up request while sense_up=1, or down request while sense_down=1: dropped. No pulse, no lockout, and the next lower source is evaluated in the same cycle.
- While obstruct=1, all down requests (including auto-close) are suppressed.

Obstruction preemption
- If obstruct=1 while in DRIVE with key_down=1 or in LOCKOUT, at the next edge: state=DRIVE, key_down=0, key_up=1, grant=100, pulse counter restarts.
- Obstruction during an up pulse has no effect.

Auto-close timer
- Counts while state=IDLE, sense_up=1, auto_en=1 and obstruct=0; cleared to 0 otherwise.
- When the count reaches AUTO_CLOSE_CYC-1, the pending flag sets and the counter holds.
- The flag clears when served, or when sense_up, auto_en or obstruct leave the counting condition.

Level requests
- Requests are level-sensitive. A request still held after LOCKOUT is served again, unless it is dropped by the sense rules above.

Test Plan:
1. Reset: rst_n=0 for 3 edges with wall_up=1 → key_up=key_down=0, grant=000, busy=0. After rst_n=1, key_up=1 from the second edge for exactly 4 cycles, then busy=1 for 2000 cycles.
2. Arbitration: in IDLE, assert wall_down=1 and rem_up=1 in the same cycle, door mid-travel → key_down pulse, grant=001. rem_up is ignored during lockout and served only after busy falls.
3. Safety and redundancy:
   - wall_up=wall_down=1 → key_up pulse.
   - rem_down=1 with sense_down=1 → no pulse, busy stays 0.
4. Obstruction preempt: during a key_down pulse at cycle 2, assert obstruct=1 → next cycle key_down=0, key_up=1 for 4 cycles, grant=100. rem_down during obstruct gives no pulse.
5. Auto-close (AUTO_CLOSE_CYC=100): sense_up=1, auto_en=1, idle → key_down with grant=011 after 100 idle cycles.
   - obstruct pulse at cycle 50 → counter restarts from 0.
   - auto_en=0 → no pulse.
6. Mid-operation reset: rst_n=0 during LOCKOUT with a request pending → all outputs 0 at that edge, and the next command is served immediately after release.
